cva6_icache_refill_writer: RTL and testbench

//  Upstream stage of the I$ data SRAM macro. Collects memory refill beats into
//  one DataWidth line, then writes it into a single way of the data SRAM.

---
 rtl/cva6_icache_refill_writer.sv | 181 ++++++++++++++++++
 tb/tb_cva6_icache_refill_writer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cva6_icache_refill_writer.sv
// I$ refill writer: gathers refill beats into one line and writes it into one data SRAM way,
// arbitrating against fetch lookups. Defining ICACHE_REFILL_BYPASS_EN adds a miss-line bypass output.
module cva6_icache_refill_writer #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned BeatWidth = 64,
  parameter int unsigned WAY_COUNT = 1,
  parameter int unsigned MaxStall  = 8,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth   = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 refill_req_i,
  input  logic [WAY_COUNT-1:0] refill_way_i,
  input  logic [AddrWidth-1:0] refill_addr_i,
  output logic                 refill_gnt_o,
  input  logic                 beat_valid_i,
  input  logic [BeatWidth-1:0] beat_data_i,
  output logic                 beat_ready_o,
  input  logic                 lookup_req_i,
  input  logic [AddrWidth-1:0] lookup_addr_i,
  output logic                 lookup_gnt_o,
  output logic [WAY_COUNT-1:0] sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  output logic                 busy_o,
`ifdef ICACHE_REFILL_BYPASS_EN
  output logic                 done_o,
  output logic                 bypass_valid_o,
  output logic [DataWidth-1:0] bypass_data_o
`else
  output logic                 done_o
`endif
);

  localparam int unsigned Beats      = DataWidth / BeatWidth;
  localparam int unsigned CntWidth   = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned StallWidth = $clog2(MaxStall + 1);
  localparam logic [CntWidth-1:0]   LastBeat   = CntWidth'(Beats - 1);
  localparam logic [StallWidth-1:0] StallLimit = StallWidth'(MaxStall);

  // state    | meaning
  // ST_IDLE  | waiting for refill_req_i
  // ST_FILL  | accepting refill beats into the line buffer
  // ST_WRITE | full line held; write it once lookups yield or stall limit reached
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE
  } state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   beat_cnt_q, beat_cnt_d;
  logic [StallWidth-1:0] stall_cnt_q, stall_cnt_d;
  logic [DataWidth-1:0]  line_q, line_d;
  logic [WAY_COUNT-1:0]  way_q, way_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;

  logic refill_gnt;
  logic beat_ready;
  logic write_fire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
      line_q      <= '0;
      way_q       <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      line_q      <= line_d;
      way_q       <= way_d;
      addr_q      <= addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    line_d      = line_q;
    way_d       = way_q;
    addr_d      = addr_q;
    refill_gnt  = 1'b0;
    beat_ready  = 1'b0;
    write_fire  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (refill_req_i && !flush_i) begin
          refill_gnt = 1'b1;
          way_d      = refill_way_i;
          addr_d     = refill_addr_i;
          beat_cnt_d = '0;
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        if (flush_i) begin
          beat_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          beat_ready = 1'b1;
          if (beat_valid_i) begin
            line_d[int'(beat_cnt_q) * BeatWidth +: BeatWidth] = beat_data_i;
            if (beat_cnt_q == LastBeat) begin
              beat_cnt_d = '0;
              state_d    = ST_WRITE;
            end else begin
              beat_cnt_d = beat_cnt_q + 1'b1;
            end
          end
        end
      end
      ST_WRITE: begin
        // Fetch keeps priority until it has stalled the write MaxStall cycles in a row.
        if (flush_i) begin
          stall_cnt_d = '0;
          state_d     = ST_IDLE;
        end else if (lookup_req_i && (stall_cnt_q < StallLimit)) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
          write_fire  = 1'b1;
          stall_cnt_d = '0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are held at zero while reset is asserted, including the lookup pass-through.
  always_comb begin
    refill_gnt_o = 1'b0;
    beat_ready_o = 1'b0;
    lookup_gnt_o = 1'b0;
    sram_req_o   = '0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
`ifdef ICACHE_REFILL_BYPASS_EN
    bypass_valid_o = 1'b0;
    bypass_data_o  = '0;
`endif
    if (!rst_i) begin
      refill_gnt_o = refill_gnt;
      beat_ready_o = beat_ready;
      busy_o       = (state_q != ST_IDLE);
      done_o       = write_fire;
      if (write_fire) begin
        sram_req_o   = way_q;
        sram_we_o    = 1'b1;
        sram_addr_o  = addr_q;
        sram_wdata_o = line_q;
        sram_be_o    = '1;
`ifdef ICACHE_REFILL_BYPASS_EN
        bypass_valid_o = 1'b1;
        bypass_data_o  = line_q;
`endif
      end else begin
        sram_req_o   = {WAY_COUNT{lookup_req_i}};
        sram_addr_o  = lookup_addr_i;
        lookup_gnt_o = lookup_req_i;
      end
    end
  end

endmodule

// File: tb/tb_cva6_icache_refill_writer.sv
// Bench for cva6_icache_refill_writer: directed vector table, corner-case sequences and a
// randomized run checked against a line-level reference model.
module tb_cva6_icache_refill_writer;

  localparam int NW  = 1024;
  localparam int DW  = 128;
  localparam int BW  = 64;
  localparam int WC  = 4;
  localparam int MS  = 8;
  localparam int AW  = 10;
  localparam int BEW = DW / 8;
  localparam int NB  = DW / BW;

  logic          clk = 1'b0;
  logic          rst, flush, req, bv, lk;
  logic [WC-1:0] way;
  logic [AW-1:0] addr, la;
  logic [BW-1:0] bd;

  logic           refill_gnt_o, beat_ready_o, lookup_gnt_o, sram_we_o, busy_o, done_o;
  logic [WC-1:0]  sram_req_o;
  logic [AW-1:0]  sram_addr_o;
  logic [DW-1:0]  sram_wdata_o;
  logic [BEW-1:0] sram_be_o;
`ifdef ICACHE_REFILL_BYPASS_EN
  logic           bypass_valid_o;
  logic [DW-1:0]  bypass_data_o;
`endif

  always #5 clk = ~clk;

  cva6_icache_refill_writer #(
    .NumWords (NW),
    .DataWidth(DW),
    .BeatWidth(BW),
    .WAY_COUNT(WC),
    .MaxStall (MS)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .refill_req_i (req),
    .refill_way_i (way),
    .refill_addr_i(addr),
    .refill_gnt_o (refill_gnt_o),
    .beat_valid_i (bv),
    .beat_data_i  (bd),
    .beat_ready_o (beat_ready_o),
    .lookup_req_i (lk),
    .lookup_addr_i(la),
    .lookup_gnt_o (lookup_gnt_o),
    .sram_req_o   (sram_req_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_be_o    (sram_be_o),
    .busy_o       (busy_o),
`ifdef ICACHE_REFILL_BYPASS_EN
    .done_o        (done_o),
    .bypass_valid_o(bypass_valid_o),
    .bypass_data_o (bypass_data_o)
`else
    .done_o       (done_o)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: tracks whether a refill is open, how many beats have arrived,
  // the assembled line and how long a complete line has been held back by lookups.
  bit            m_active;
  int            m_got, m_stalls;
  logic [DW-1:0] m_line;
  logic [WC-1:0] m_way;
  logic [AW-1:0] m_addr;

  logic           e_gnt, e_rdy, e_we, e_lgnt, e_busy, e_done;
  logic [WC-1:0]  e_sreq;
  logic [AW-1:0]  e_saddr;
  logic [DW-1:0]  e_wdata;
  logic [BEW-1:0] e_be;

  function automatic void model_predict();
    e_gnt = 0; e_rdy = 0; e_we = 0; e_lgnt = 0; e_busy = 0; e_done = 0;
    e_sreq = '0; e_saddr = '0; e_wdata = '0; e_be = '0;
    if (!rst) begin
      e_busy = m_active;
      e_gnt  = !m_active && req && !flush;
      e_rdy  = m_active && (m_got < NB) && !flush;
      e_done = m_active && (m_got == NB) && !flush && !(lk && (m_stalls < MS));
      if (e_done) begin
        e_sreq = m_way; e_we = 1; e_saddr = m_addr; e_wdata = m_line; e_be = '1;
      end else begin
        e_sreq = {WC{lk}}; e_saddr = la; e_lgnt = lk;
      end
    end
  endfunction

  function automatic void model_update();
    if (rst) begin
      m_active = 0; m_got = 0; m_stalls = 0; m_line = '0;
    end else if (flush) begin
      m_active = 0; m_got = 0; m_stalls = 0;
    end else if (!m_active) begin
      if (req) begin
        m_active = 1; m_way = way; m_addr = addr; m_got = 0;
      end
    end else if (m_got < NB) begin
      if (bv) begin
        m_line[m_got*BW +: BW] = bd;
        m_got++;
      end
    end else if (e_done) begin
      m_active = 0; m_got = 0; m_stalls = 0;
    end else begin
      m_stalls++;
    end
  endfunction

  logic           s_gnt, s_rdy, s_we, s_lgnt, s_busy, s_done;
  logic [WC-1:0]  s_sreq;
  logic [AW-1:0]  s_saddr;
  logic [DW-1:0]  s_wdata;

  // Entered 1 time unit after a rising edge with inputs already applied; samples at the falling edge.
  task automatic run_cycle();
    #4;
    model_predict();
    s_gnt = refill_gnt_o; s_rdy = beat_ready_o; s_we = sram_we_o; s_lgnt = lookup_gnt_o;
    s_busy = busy_o; s_done = done_o; s_sreq = sram_req_o; s_saddr = sram_addr_o; s_wdata = sram_wdata_o;
    chk("refill_gnt", refill_gnt_o, e_gnt);
    chk("beat_ready", beat_ready_o, e_rdy);
    chk("lookup_gnt", lookup_gnt_o, e_lgnt);
    chk("sram_req", sram_req_o, e_sreq);
    chk("sram_we", sram_we_o, e_we);
    chk("sram_addr", sram_addr_o, e_saddr);
    chk("sram_wdata", sram_wdata_o, e_wdata);
    chk("sram_be", sram_be_o, e_be);
    chk("busy", busy_o, e_busy);
    chk("done", done_o, e_done);
`ifdef ICACHE_REFILL_BYPASS_EN
    chk("bypass_valid", bypass_valid_o, e_done);
    chk("bypass_data", bypass_data_o, e_done ? e_wdata : '0);
`endif
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rst = 0; flush = 0; req = 0; way = '0; addr = '0; bv = 0; bd = '0; lk = 0; la = '0;
  endtask

  task automatic refill_to_write(input logic [WC-1:0] w, input logic [AW-1:0] a,
                                 input logic [BW-1:0] b0, input logic [BW-1:0] b1);
    req = 1; way = w; addr = a; bv = 0;
    run_cycle();
    chk("seq_refill_gnt", s_gnt, 1'b1);
    req = 0; bv = 1; bd = b0;
    run_cycle();
    bd = b1;
    run_cycle();
    bv = 0;
  endtask

  typedef struct {
    logic rst, flush, req; logic [WC-1:0] way; logic [AW-1:0] addr;
    logic bv; logic [BW-1:0] bd; logic lk; logic [AW-1:0] la;
    logic x_gnt, x_rdy; logic [WC-1:0] x_sreq; logic x_we; logic [AW-1:0] x_saddr;
    logic [DW-1:0] x_wdata; logic x_lgnt, x_busy, x_done;
  } vec_t;

  function automatic vec_t mk(input logic r, f, q, input logic [WC-1:0] w, input logic [AW-1:0] a,
                              input logic v, input logic [BW-1:0] d, input logic l, input logic [AW-1:0] lad,
                              input logic xg, xr, input logic [WC-1:0] xs, input logic xw,
                              input logic [AW-1:0] xa, input logic [DW-1:0] xd, input logic xl, xb, xdn);
    vec_t t;
    t.rst = r; t.flush = f; t.req = q; t.way = w; t.addr = a; t.bv = v; t.bd = d; t.lk = l; t.la = lad;
    t.x_gnt = xg; t.x_rdy = xr; t.x_sreq = xs; t.x_we = xw; t.x_saddr = xa; t.x_wdata = xd;
    t.x_lgnt = xl; t.x_busy = xb; t.x_done = xdn;
    return t;
  endfunction

  localparam logic [BW-1:0] PA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [BW-1:0] P5 = 64'h5555_5555_5555_5555;
  localparam logic [BW-1:0] PX = 64'h1234_5678_9ABC_DEF0;
  localparam logic [BW-1:0] PY = 64'h0FED_CBA9_8765_4321;

  vec_t tbl[$];

  initial begin
    set_idle();
    rst = 1;
    @(posedge clk);
    #1;

    //        rst f req way     addr   bv bd  lk la     gnt rdy sreq    we saddr  wdata      lgnt busy done
    tbl.push_back(mk(1, 0, 1, 4'b0010, 10'h5, 0, '0, 1, 10'h3, 0, 0, 4'b0000, 0, 10'h0, '0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'b0010, 10'h5, 0, '0, 1, 10'h7, 1, 0, 4'b1111, 0, 10'h7, '0,        1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 10'h0, 1, PA, 0, 10'h7, 0, 1, 4'b0000, 0, 10'h7, '0,        0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 10'h0, 0, '0, 0, 10'h7, 0, 1, 4'b0000, 0, 10'h7, '0,        0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 10'h0, 1, P5, 0, 10'h7, 0, 1, 4'b0000, 0, 10'h7, '0,        0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 10'h0, 0, '0, 0, 10'h7, 0, 0, 4'b0010, 1, 10'h5, {P5, PA},  0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 10'h0, 0, '0, 1, 10'h9, 0, 0, 4'b1111, 0, 10'h9, '0,        1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'b0000, 10'hC, 0, '0, 0, 10'h0, 1, 0, 4'b0000, 0, 10'h0, '0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 10'h0, 1, PX, 0, 10'h0, 0, 1, 4'b0000, 0, 10'h0, '0,        0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 10'h0, 1, PY, 0, 10'h0, 0, 1, 4'b0000, 0, 10'h0, '0,        0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 10'h0, 0, '0, 0, 10'h0, 0, 0, 4'b0000, 1, 10'hC, {PY, PX},  0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 10'h0, 0, '0, 0, 10'h0, 0, 0, 4'b0000, 0, 10'h0, '0,        0, 0, 0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; flush = tbl[i].flush; req = tbl[i].req; way = tbl[i].way; addr = tbl[i].addr;
      bv = tbl[i].bv; bd = tbl[i].bd; lk = tbl[i].lk; la = tbl[i].la;
      run_cycle();
      chk($sformatf("vec%0d_gnt", i), s_gnt, tbl[i].x_gnt);
      chk($sformatf("vec%0d_ready", i), s_rdy, tbl[i].x_rdy);
      chk($sformatf("vec%0d_sram_req", i), s_sreq, tbl[i].x_sreq);
      chk($sformatf("vec%0d_we", i), s_we, tbl[i].x_we);
      chk($sformatf("vec%0d_addr", i), s_saddr, tbl[i].x_saddr);
      chk($sformatf("vec%0d_wdata", i), s_wdata, tbl[i].x_wdata);
      chk($sformatf("vec%0d_lookup_gnt", i), s_lgnt, tbl[i].x_lgnt);
      chk($sformatf("vec%0d_busy", i), s_busy, tbl[i].x_busy);
      chk($sformatf("vec%0d_done", i), s_done, tbl[i].x_done);
    end

    // Lookup held through WRITE: MaxStall granted reads, then the write wins.
    set_idle();
    refill_to_write(4'b0100, 10'h3C, PX, PA);
    lk = 1; la = 10'h11;
    for (int k = 0; k < MS; k++) begin
      run_cycle();
      chk($sformatf("stall%0d_lookup_gnt", k), s_lgnt, 1'b1);
      chk($sformatf("stall%0d_we", k), s_we, 1'b0);
    end
    run_cycle();
    chk("stall_release_we", s_we, 1'b1);
    chk("stall_release_lookup_gnt", s_lgnt, 1'b0);
    chk("stall_release_done", s_done, 1'b1);
    chk("stall_release_wdata", s_wdata, {PA, PX});
    lk = 0;
    run_cycle();
    chk("stall_after_busy", s_busy, 1'b0);

    // Flush after the first beat; the next refill restarts at beat 0.
    set_idle();
    req = 1; way = 4'b1000; addr = 10'h21;
    run_cycle();
    req = 0; bv = 1; bd = PY;
    run_cycle();
    flush = 1; bd = P5;
    run_cycle();
    chk("flush_fill_ready", s_rdy, 1'b0);
    chk("flush_fill_we", s_we, 1'b0);
    flush = 0; bv = 0;
    run_cycle();
    chk("flush_fill_busy", s_busy, 1'b0);
    chk("flush_fill_done", s_done, 1'b0);
    refill_to_write(4'b0001, 10'h2, P5, PX);
    run_cycle();
    chk("refill_after_flush_wdata", s_wdata, {PX, P5});
    chk("refill_after_flush_done", s_done, 1'b1);

    // Flush in the would-be write cycle.
    set_idle();
    refill_to_write(4'b0010, 10'h7F, PA, PY);
    flush = 1;
    run_cycle();
    chk("flush_write_we", s_we, 1'b0);
    chk("flush_write_done", s_done, 1'b0);
    flush = 0;
    run_cycle();
    chk("flush_write_busy", s_busy, 1'b0);
    chk("flush_write_we_after", s_we, 1'b0);

    // Reset mid-fill: outputs clear immediately, then a new request is granted.
    set_idle();
    req = 1; way = 4'b0100; addr = 10'h15;
    run_cycle();
    req = 0; bv = 1; bd = PA;
    run_cycle();
    rst = 1; req = 1; lk = 1; la = 10'h5;
    run_cycle();
    chk("rst_fill_busy", s_busy, 1'b0);
    chk("rst_fill_lookup_gnt", s_lgnt, 1'b0);
    chk("rst_fill_sram_req", s_sreq, '0);
    chk("rst_fill_ready", s_rdy, 1'b0);
    chk("rst_fill_gnt", s_gnt, 1'b0);
    rst = 0; lk = 0; bv = 0;
    run_cycle();
    chk("rst_release_gnt", s_gnt, 1'b1);
    req = 0; bv = 1; bd = P5;
    run_cycle();
    bd = PY;
    run_cycle();
    bv = 0;
    run_cycle();
    chk("rst_release_wdata", s_wdata, {PY, P5});

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 39) == 0);
      req   = ($urandom_range(0, 2) != 0);
      way   = WC'($urandom);
      addr  = AW'($urandom);
      bv    = ($urandom_range(0, 9) < 6);
      bd    = {$urandom, $urandom};
      lk    = ($urandom_range(0, 9) < 7);
      la    = AW'($urandom);
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
